// File: rtl/dr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dr_pkg
// Description : Shared dual-rail codeword constants and helpers for the adder
//               datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package dr_pkg;

    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ILL  = 2'b11;

    localparam int ADD_W = 16;

    function automatic logic dr_pair_bad(input logic [1:0] pair);
        return (pair == DR_NULL) || (pair == DR_ILL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dr_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : dr_result_collector_if
// Description : Dual-rail input, decoded-result output and error-counter
//               signals of the result collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface dr_result_collector_if #(
    parameter int W     = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_dr;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic             clr_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_dr, out_ready, clr_err,
        input  in_ready, out_valid, out_data, out_err, err_count
    );

    modport slave (
        input  in_valid, in_dr, out_ready, clr_err,
        output in_ready, out_valid, out_data, out_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/dr_word_decode.sv
`default_nettype none
// ============================================================================
// Module      : dr_word_decode
// Description : Combinational dual-rail to binary decode with a word-level
//               malformed flag (any NULL or ILLEGAL pair).
// Revision    : 1.0 - initial release
// ============================================================================
module dr_word_decode
    import dr_pkg::*;
#(
    parameter int W = ADD_W
) (
    input  wire logic [2*W-1:0] i_dr,
    output logic      [W-1:0]   o_data,
    output logic                o_err
);

    logic [W-1:0] w_pair_bad;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pair
            // The true rail alone drives the bit, even for malformed pairs.
            assign o_data[gi]     = i_dr[2*gi+1];
            assign w_pair_bad[gi] = dr_pair_bad(i_dr[2*gi+1 -: 2]);
        end
    endgenerate

    assign o_err = |w_pair_bad;

endmodule
`default_nettype wire

// File: rtl/dr_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : dr_result_collector
// Description : Checks and decodes dual-rail sum words, buffers them in a
//               small FIFO and keeps a saturating malformed-word count.
// Revision    : 1.0 - initial release
// ============================================================================
module dr_result_collector
    import dr_pkg::*;
#(
    parameter int W     = ADD_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    dr_result_collector_if.slave  bus
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(DEPTH);

    logic [W:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [CNT_W-1:0]   r_err_count;

    logic [W-1:0] w_dec_data;
    logic         w_dec_err;
    logic         w_push;
    logic         w_pop;
    logic [W:0]   w_head;

    dr_word_decode #(.W(W)) u_decode (
        .i_dr   (bus.in_dr),
        .o_data (w_dec_data),
        .o_err  (w_dec_err)
    );

    // Handshake status depends only on the registered occupancy.
    assign bus.in_ready  = (r_count < c_FULL);
    assign bus.out_valid = (r_count != '0);

    assign w_push = bus.in_valid  & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.out_data  = bus.out_valid ? w_head[W-1:0] : '0;
    assign bus.out_err   = bus.out_valid & w_head[W];
    assign bus.err_count = r_err_count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_dec_err, w_dec_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (bus.clr_err) begin
            r_err_count <= '0;
        end else if (w_push && w_dec_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dr_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_dr_result_collector
// Description : Directed bench for the result collector with a result queue
//               and occupancy / error-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dr_result_collector;

    localparam int c_W     = 16;
    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 8;

    logic clk;
    logic rst_n;

    dr_result_collector_if #(.W(c_W), .CNT_W(c_CNT_W)) bus ();

    dr_result_collector #(.W(c_W), .DEPTH(c_DEPTH), .CNT_W(c_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total;
    int          passed;
    int          failed;
    logic [16:0] sb_q [$];
    int          m_err;

    function automatic logic [16:0] ref_decode(input logic [31:0] dr);
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = dr[2*i+1];
            if (dr[2*i+1] == dr[2*i]) r[16] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check current outputs against the model, drive, advance.
    task automatic cycle(input logic v, input logic [31:0] dr, input logic ordy, input logic clr);
        logic e_ready, e_valid, push, pop;
        logic [16:0] dec;
        e_ready = (sb_q.size() < c_DEPTH);
        e_valid = (sb_q.size() > 0);
        chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("err_count", 32'(bus.err_count), 32'(m_err));
        if (!e_valid) begin
            chk("idle_data", 32'(bus.out_data), 32'h0);
            chk("idle_err", 32'(bus.out_err), 32'h0);
        end
        bus.in_valid  = v;
        bus.in_dr     = dr;
        bus.out_ready = ordy;
        bus.clr_err   = clr;
        push = v & e_ready;
        pop  = e_valid & ordy;
        dec  = ref_decode(dr);
        if (pop) begin
            logic [16:0] head;
            head = sb_q.pop_front();
            chk("pop_data", 32'(bus.out_data), 32'(head[15:0]));
            chk("pop_err", 32'(bus.out_err), 32'(head[16]));
        end
        if (push) sb_q.push_back(dec);
        if (clr) m_err = 0;
        else if (push && dec[16] && m_err != 255) m_err++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    logic [31:0] fill_words [4];
    logic [15:0] fill_exp   [4];

    initial begin
        total = 0; passed = 0; failed = 0; m_err = 0;
        fill_words = '{32'h55555555, 32'hAAAAAAAA, 32'h56595A65, 32'h55555556};
        fill_exp   = '{16'h0000, 16'hFFFF, 16'h1234, 16'h0001};
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_dr = '0; bus.out_ready = 1'b0; bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_err", 32'(bus.out_err), 32'h0);
        chk("rst_err_count", 32'(bus.err_count), 32'h0);

        // Single word, one-cycle latency
        cycle(1'b1, 32'h56595A65, 1'b1, 1'b0);
        chk("single_valid", 32'(bus.out_valid), 32'h1);
        chk("single_data", 32'(bus.out_data), 32'h1234);
        chk("single_err", 32'(bus.out_err), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single_empty", 32'(bus.out_valid), 32'h0);

        // Fill to full, fifth word refused, ordered drain
        for (int i = 0; i < 4; i++) cycle(1'b1, fill_words[i], 1'b0, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        cycle(1'b1, 32'hAAAAAAAB, 1'b0, 1'b0);
        chk("refused_no_err", 32'(bus.err_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(bus.out_data), 32'(fill_exp[i]));
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(bus.out_valid), 32'h0);

        // Malformed words
        cycle(1'b1, 32'hAAAAAAAB, 1'b0, 1'b0);
        chk("ill_data", 32'(bus.out_data), 32'hFFFF);
        chk("ill_err", 32'(bus.out_err), 32'h1);
        chk("ill_count", 32'(bus.err_count), 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h55555554, 1'b0, 1'b0);
        chk("null_data", 32'(bus.out_data), 32'h0000);
        chk("null_err", 32'(bus.out_err), 32'h1);
        chk("null_count", 32'(bus.err_count), 32'h2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Concurrent push/pop at count 2, then pop while full
        cycle(1'b1, 32'h55555556, 1'b0, 1'b0);
        cycle(1'b1, 32'h56595A65, 1'b0, 1'b0);
        cycle(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
        cycle(1'b1, 32'h55555555, 1'b0, 1'b0);
        chk("cc_not_full", 32'(bus.in_ready), 32'h1);
        cycle(1'b1, 32'h56595A65, 1'b0, 1'b0);
        chk("cc_full", 32'(bus.in_ready), 32'h0);
        cycle(1'b1, 32'h55555556, 1'b1, 1'b0);
        chk("cc_after_pop", 32'(bus.in_ready), 32'h1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Saturation and clear priority
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'hAAAAAAAB, 1'b1, 1'b0);
        chk("sat_count", 32'(bus.err_count), 32'd255);
        cycle(1'b1, 32'hAAAAAAAB, 1'b1, 1'b1);
        chk("clr_count", 32'(bus.err_count), 32'h0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Mid-run reset discards queued entries
        repeat (3) cycle(1'b1, 32'h55555554, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        m_err = 0;
        chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
        chk("post_rst_count", 32'(bus.err_count), 32'h0);
        cycle(1'b1, 32'h56595A65, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dr_result_collector.md
# dr_result_collector

Downstream stage of the 16-bit dual-rail adder datapath. Consumes the 32-bit dual-rail sum word from the adder and checks every rail pair for a legal codeword. It decodes the word to 16-bit binary and buffers results in a small FIFO with a valid/ready output handshake. It also keeps a saturating count of malformed words for bring-up and debug.

## Interface
Parameters:
- W, 16, binary result width; dual-rail input is 2*W bits.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- in_valid  in  1  in_dr holds a word to accept.
- in_ready  out  1  collector can accept; equals (count < DEPTH).
- in_dr  in  2*W  dual-rail sum; pair i = {in_dr[2i+1], in_dr[2i]}.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head.
- out_data  out  W  decoded head result; 0 when out_valid=0.
- out_err  out  1  head entry was malformed; 0 when out_valid=0.
- clr_err  in  1  clear err_count.
- err_count  out  CNT_W  saturating count of accepted malformed words.

## Operation
- Pair codewords: 2'b01 = binary 0, 2'b10 = binary 1, 2'b00 = NULL (spacer), 2'b11 = ILLEGAL.
- Decode: out bit i = in_dr[2i+1] regardless of pair legality (matches the existing converter rule).
- Word error flag = any pair NULL or ILLEGAL; stored alongside the data in the same FIFO entry.
- Push when in_valid & in_ready; pop when out_valid & out_ready.
- FIFO: DEPTH entries of W+1 bits, wrap-around read/write pointers, occupancy counter 0..DEPTH.
- Simultaneous push and pop: both occur, count unchanged; allowed at any count 1..DEPTH-1.
- Full (count=DEPTH): in_ready=0 even if a pop happens the same cycle (no pass-through); a push attempt is ignored.
- Empty: out_valid=0; no bypass from input to output.
- err_count increments by 1 on each accepted word with the error flag set. It saturates at 2^CNT_W−1.
- clr_err has priority: when clr_err=1 the counter becomes 0 that cycle, even if an erroneous push occurs.
- Words not accepted (in_ready=0) never affect err_count.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, out_data=0, out_err=0, in_ready=1, err_count=0. FIFO storage is not cleared.
- Latency: a word accepted on edge N is visible on out_valid/out_data after edge N (available in cycle N+1), when the FIFO was empty.
- in_ready and out_valid are pure functions of the registered count, with no combinational path from in_valid or out_ready.
- Order is strictly FIFO.
- rst_n low during operation discards all entries at that edge. Data is lost; err_count returns to 0.

## Structure
- Shared package dr_pkg holds:
  - codeword constants DR_ZERO=2'b01, DR_ONE=2'b10, DR_NULL=2'b00, DR_ILL=2'b11;
  - width constant ADD_W=16.
- Sub-module dr_word_decode (combinational, parameter W) maps in_dr to {err, data[W-1:0]}.
- The top holds the FIFO, pointers, count and error counter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles. Expect in_ready=1, out_valid=0, out_data=0x0000, out_err=0, err_count=0.
- Single word: push in_dr=32'h56595A65 with out_ready=1. Next cycle expect out_valid=1, out_data=0x1234, out_err=0. Following cycle expect out_valid=0.
- Fill/backpressure: with out_ready=0, push 32'h55555555, 32'hAAAAAAAA, 32'h56595A65, 32'h55555556, then a fifth word.
  - in_ready drops after the 4th push; the 5th is not accepted.
  - Drain yields 0x0000, 0xFFFF, 0x1234, 0x0001 in order, then out_valid=0.
- Malformed words:
  - Push 32'hAAAAAAAB (pair 0 ILLEGAL). Expect out_data=0xFFFF, out_err=1, err_count=1.
  - Push 32'h55555554 (pair 0 NULL). Expect out_data=0x0000, out_err=1, err_count=2.
- Concurrency: at count=2 push and pop the same cycle; count stays 2. At count=4 with out_ready=1, in_ready=0 that cycle and count goes to 3.
- Counter and reset:
  - Push 300 ILLEGAL words, draining continuously. err_count reaches 255 and holds.
  - Assert clr_err together with an erroneous push; err_count becomes 0.
  - With 3 entries queued, pulse rst_n=0 for one cycle; out_valid=0 afterwards.
